// File: rtl/mod_add_sub_seq.sv
// mod_add_sub_seq: limb-serial (a +/- b) mod p over two fixed passes of one W-bit slice.
// Define MOD_ADD_SUB_RANGE_CHECK_EN to build the a>=p / b>=p range check driving err.
module mod_add_sub_seq #(
  parameter int N = 256,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         err
);
  localparam int L = N / W;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST = CW'(L - 1);
  typedef enum logic [2:0] {IDLE, PASS1, PASS2, SEL, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, cy_q, cy_d, c1_q, c1_d, err_q, err_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, p_q, p_d, t_q, t_d, u_q, u_d, res_q, res_d;
  logic [N-1:0] p_rot;
  logic [W-1:0] x, y;
  logic [W:0] s;
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
  logic ga_q, ga_d, gb_q, gb_d;
`endif
  // One shared slice: PASS1 adds a and (+/-)b, PASS2 adds t and (-/+)p.
  assign x = (state_q == PASS1) ? a_q[W-1:0] : t_q[W-1:0];
  assign y = (state_q == PASS1) ? (op_q ? ~b_q[W-1:0] : b_q[W-1:0])
                                : (op_q ? p_q[W-1:0] : ~p_q[W-1:0]);
  assign s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cy_q};
  assign p_rot = (p_q >> W) | (p_q << (N - W));
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = res_q;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    cy_d = cy_q;
    c1_d = c1_q;
    err_d = err_q;
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    t_d = t_q;
    u_d = u_q;
    res_d = res_q;
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
    ga_d = ga_q;
    gb_d = gb_q;
`endif
    unique case (state_q)
      IDLE: if (in_valid) begin
        op_d = op;
        a_d = a;
        b_d = b;
        p_d = p;
        cy_d = op;
        cnt_d = '0;
        state_d = PASS1;
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
        ga_d = 1'b1;
        gb_d = 1'b1;
`endif
      end
      PASS1: begin
        a_d = a_q >> W;
        b_d = b_q >> W;
        p_d = p_rot;
        t_d = (t_q >> W) | (N'(s[W-1:0]) << (N - W));
        cy_d = s[W];
        cnt_d = cnt_q + CW'(1);
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
        // LSB-first >= chains: a higher limb decides, equal limbs defer to lower ones.
        ga_d = (a_q[W-1:0] > p_q[W-1:0]) | ((a_q[W-1:0] == p_q[W-1:0]) & ga_q);
        gb_d = (b_q[W-1:0] > p_q[W-1:0]) | ((b_q[W-1:0] == p_q[W-1:0]) & gb_q);
`endif
        if (cnt_q == LAST) begin
          c1_d = s[W];
          cy_d = ~op_q;
          cnt_d = '0;
          state_d = PASS2;
        end
      end
      PASS2: begin
        t_d = (t_q >> W) | (t_q << (N - W));
        p_d = p_rot;
        u_d = (u_q >> W) | (N'(s[W-1:0]) << (N - W));
        cy_d = s[W];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d = '0;
          state_d = SEL;
        end
      end
      SEL: begin
        // cy_q now holds the PASS2 carry (not-borrow for add).
        res_d = (op_q ? ~c1_q : (c1_q | cy_q)) ? u_q : t_q;
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
        err_d = ga_q | gb_q;
`else
        err_d = 1'b0;
`endif
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= 1'b0;
      cy_q <= 1'b0;
      c1_q <= 1'b0;
      err_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      t_q <= '0;
      u_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      cy_q <= cy_d;
      c1_q <= c1_d;
      err_q <= err_d;
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
      t_q <= t_d;
      u_q <= u_d;
      res_q <= res_d;
    end
  end
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ga_q <= 1'b0;
      gb_q <= 1'b0;
    end else begin
      ga_q <= ga_d;
      gb_q <= gb_d;
    end
  end
`endif
endmodule

// File: tb/tb_mod_add_sub_seq.sv
// tb_mod_add_sub_seq: scoreboard bench for mod_add_sub_seq with an arithmetic reference model.
module tb_mod_add_sub_seq;
  localparam int N = 256;
  localparam int W = 64;
  localparam int LAT = 2 * (N / W) + 1;
  logic clk = 0, rst = 1, in_valid = 0, op = 0, out_ready = 1;
  logic in_ready, out_valid, err;
  logic [N-1:0] a = 0, b = 0, p = 0, result;
  typedef struct {logic [N-1:0] res; logic err; int acc;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0;
  logic ov_prev = 0;
  mod_add_sub_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .p(p), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [N-1:0] model(input logic o, input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] m);
    logic [N:0] r;
    if (!o) begin
      r = {1'b0, x} + {1'b0, y};
      if (r >= {1'b0, m}) r = r - {1'b0, m};
    end else begin
      r = {1'b0, x} - {1'b0, y};
      if (x < y) r = r + {1'b0, m};
    end
    return r[N-1:0];
  endfunction
  function automatic logic model_err(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] m);
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
    return (x >= m) | (y >= m);
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [N-1:0] rnd();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N / 32; i++) r = {r[N-33:0], $urandom};
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic issue(input logic o, input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] m);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: in_ready=0 required 1");
      return;
    end
    in_valid = 1;
    op = o;
    a = x;
    b = y;
    p = m;
    tick();
    sb.push_back('{model(o, x, y, m), model_err(x, y, m), cyc});
    in_valid = 0;
    op = ~o;
    a = rnd();
    b = rnd();
    p = rnd();
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask
  always @(negedge clk) begin
    if (rst) ov_prev = 0;
    else begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out_valid: out_valid=1 with nothing outstanding");
        end else chk("latency", N'(cyc - sb[0].acc), N'(LAT));
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("err", N'(err), N'(e.err));
      end
      ov_prev = out_valid;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [N-1:0] big, m, x, y, hold;
    #1;
    chk("rst_in_ready", N'(in_ready), N'(1));
    chk("rst_out_valid", N'(out_valid), N'(0));
    chk("rst_result", result, '0);
    chk("rst_err", N'(err), N'(0));
    tick();
    rst = 0;
    tick();
    issue(0, 5, 7, 13);
    issue(0, 8, 9, 13);
    issue(1, 3, 5, 13);
    big = '1;
    big = big - 188;
    issue(0, big - 1, big - 1, big);
    issue(1, 9, 4, 13);
    drain();
    // Backpressure: hold the result for 10 cycles while poking in_valid.
    out_ready = 0;
    issue(0, 8, 9, 13);
    hold = model(0, 8, 9, 13);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", N'(out_valid), N'(1));
      chk("bp_result", result, hold);
      chk("bp_in_ready", N'(in_ready), N'(0));
      in_valid = i[0];
      op = 1;
      a = 1;
      b = 2;
      p = 13;
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    chk("bp_release_out_valid", N'(out_valid), N'(0));
    chk("bp_release_in_ready", N'(in_ready), N'(1));
    drain();
    // Reset three cycles into an operation.
    issue(1, 9, 4, 13);
    tick();
    tick();
    tick();
    rst = 1;
    #1;
    chk("midrst_out_valid", N'(out_valid), N'(0));
    chk("midrst_in_ready", N'(in_ready), N'(1));
    chk("midrst_result", result, '0);
    sb.delete();
    tick();
    rst = 0;
    tick();
    issue(0, 1, 1, 13);
    issue(0, 13, 1, 13);
    issue(0, 12, 12, 13);
    drain();
    for (int i = 0; i < 24; i++) begin
      m = (i < 12) ? rnd() : N'($urandom_range(1, 1000));
      if (m == 0) m = 1;
      x = rnd() % m;
      y = rnd() % m;
      issue(1'($urandom_range(0, 1)), x, y, m);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
